// File: rtl/scr1_tb_axi_arbiter.sv
// N_IF-to-1 AXI4 arbiter sharing one single-beat AXI memory port between several masters.
// Latency: 1 cycle of arbitration; handshakes and payloads then pass through combinationally.
// Backpressure: grant is held until the response handshake; losers see ready/valid low.
module scr1_tb_axi_arbiter #(
  parameter int N_IF   = 2,
  parameter int W_ID   = 4,
  parameter int W_ADR  = 32,
  parameter int W_DATA = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  // upstream write address
  input  logic [N_IF-1:0]                    s_awvalid,
  input  logic [N_IF-1:0][W_ID-1:0]          s_awid,
  input  logic [N_IF-1:0][W_ADR-1:0]         s_awaddr,
  input  logic [N_IF-1:0][2:0]               s_awsize,
  input  logic [N_IF-1:0][7:0]               s_awlen,
  output logic [N_IF-1:0]                    s_awready,
  // upstream write data
  input  logic [N_IF-1:0]                    s_wvalid,
  input  logic [N_IF-1:0][W_DATA-1:0]        s_wdata,
  input  logic [N_IF-1:0][W_DATA/8-1:0]      s_wstrb,
  input  logic [N_IF-1:0]                    s_wlast,
  output logic [N_IF-1:0]                    s_wready,
  // upstream write response
  output logic [N_IF-1:0]                    s_bvalid,
  output logic [N_IF-1:0][W_ID-1:0]          s_bid,
  output logic [N_IF-1:0][1:0]               s_bresp,
  input  logic [N_IF-1:0]                    s_bready,
  // upstream read address
  input  logic [N_IF-1:0]                    s_arvalid,
  input  logic [N_IF-1:0][W_ID-1:0]          s_arid,
  input  logic [N_IF-1:0][W_ADR-1:0]         s_araddr,
  input  logic [N_IF-1:0][1:0]               s_arburst,
  input  logic [N_IF-1:0][2:0]               s_arsize,
  input  logic [N_IF-1:0][7:0]               s_arlen,
  output logic [N_IF-1:0]                    s_arready,
  // upstream read data
  output logic [N_IF-1:0]                    s_rvalid,
  output logic [N_IF-1:0][W_ID-1:0]          s_rid,
  output logic [N_IF-1:0][W_DATA-1:0]        s_rdata,
  output logic [N_IF-1:0]                    s_rlast,
  output logic [N_IF-1:0][1:0]               s_rresp,
  input  logic [N_IF-1:0]                    s_rready,
  // memory write address
  output logic                               m_awvalid,
  output logic [W_ID-1:0]                    m_awid,
  output logic [W_ADR-1:0]                   m_awaddr,
  output logic [2:0]                         m_awsize,
  output logic [7:0]                         m_awlen,
  input  logic                               m_awready,
  // memory write data
  output logic                               m_wvalid,
  output logic [W_DATA-1:0]                  m_wdata,
  output logic [W_DATA/8-1:0]                m_wstrb,
  output logic                               m_wlast,
  input  logic                               m_wready,
  // memory write response
  input  logic                               m_bvalid,
  input  logic [W_ID-1:0]                    m_bid,
  input  logic [1:0]                         m_bresp,
  output logic                               m_bready,
  // memory read address
  output logic                               m_arvalid,
  output logic [W_ID-1:0]                    m_arid,
  output logic [W_ADR-1:0]                   m_araddr,
  output logic [1:0]                         m_arburst,
  output logic [2:0]                         m_arsize,
  output logic [7:0]                         m_arlen,
  input  logic                               m_arready,
  // memory read data
  input  logic                               m_rvalid,
  input  logic [W_ID-1:0]                    m_rid,
  input  logic [W_DATA-1:0]                  m_rdata,
  input  logic                               m_rlast,
  input  logic [1:0]                         m_rresp,
  output logic                               m_rready
);

  localparam int W_GNT = (N_IF > 1) ? $clog2(N_IF) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;

  // First requester at or after ptr, wrapping around.
  function automatic logic [W_GNT-1:0] rr_pick(input logic [N_IF-1:0] req,
                                               input logic [W_GNT-1:0] ptr);
    logic [W_GNT-1:0] win;
    int               idx;
    win = ptr;
    for (int k = N_IF - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_IF) idx = idx - N_IF;
      if (req[W_GNT'(idx)]) win = W_GNT'(idx);
    end
    return win;
  endfunction

  function automatic logic [W_GNT-1:0] rr_next(input logic [W_GNT-1:0] gnt);
    int n;
    n = int'(gnt) + 1;
    if (n >= N_IF) n = 0;
    return W_GNT'(n);
  endfunction

  rd_state_t        rd_state, rd_state_nxt;
  logic [W_GNT-1:0] rd_gnt, rd_ptr, rd_win;
  wr_state_t        wr_state, wr_state_nxt;
  logic [W_GNT-1:0] wr_gnt, wr_ptr, wr_win;
  logic [N_IF-1:0]  wr_req;
  logic             aw_done, w_done;
  logic             aw_hs, w_hs;

  assign rd_win = rr_pick(s_arvalid, rd_ptr);
  assign wr_req = s_awvalid | s_wvalid;
  assign wr_win = rr_pick(wr_req, wr_ptr);

  // Read arbiter state, grant and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_gnt   <= '0;
      rd_ptr   <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_state == R_IDLE && |s_arvalid) begin
        rd_gnt <= rd_win;
        rd_ptr <= rr_next(rd_win);
      end
    end
  end

  // Read next-state and grant-steered handshakes.
  always_comb begin
    rd_state_nxt = rd_state;
    m_arvalid    = 1'b0;
    s_arready    = '0;
    m_rready     = 1'b0;
    s_rvalid     = '0;
    case (rd_state)
      R_IDLE: if (|s_arvalid) rd_state_nxt = R_ADDR;
      R_ADDR: begin
        m_arvalid         = s_arvalid[rd_gnt];
        s_arready[rd_gnt] = m_arready;
        if (m_arvalid && m_arready) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_rvalid[rd_gnt] = m_rvalid;
        m_rready         = s_rready[rd_gnt];
        if (m_rvalid && m_rready && m_rlast) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Write arbiter state, grant, pointer and per-channel completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_gnt   <= '0;
      wr_ptr   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      if (wr_state == W_IDLE && |wr_req) begin
        wr_gnt <= wr_win;
        wr_ptr <= rr_next(wr_win);
      end
      if (wr_state == W_XFER) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (wr_state == W_RESP && m_bvalid && m_bready) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Write next-state; a finished channel is masked so it cannot handshake twice.
  always_comb begin
    wr_state_nxt = wr_state;
    m_awvalid    = 1'b0;
    s_awready    = '0;
    m_wvalid     = 1'b0;
    s_wready     = '0;
    m_bready     = 1'b0;
    s_bvalid     = '0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    case (wr_state)
      W_IDLE: if (|wr_req) wr_state_nxt = W_XFER;
      W_XFER: begin
        m_awvalid         = s_awvalid[wr_gnt] & ~aw_done;
        s_awready[wr_gnt] = m_awready & ~aw_done;
        m_wvalid          = s_wvalid[wr_gnt] & ~w_done;
        s_wready[wr_gnt]  = m_wready & ~w_done;
        aw_hs             = m_awvalid & m_awready;
        w_hs              = m_wvalid & m_wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid[wr_gnt] = m_bvalid;
        m_bready         = s_bready[wr_gnt];
        if (m_bvalid && m_bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Request payloads come from the current grant holder.
  assign m_arid    = s_arid[rd_gnt];
  assign m_araddr  = s_araddr[rd_gnt];
  assign m_arburst = s_arburst[rd_gnt];
  assign m_arsize  = s_arsize[rd_gnt];
  assign m_arlen   = s_arlen[rd_gnt];
  assign m_awid    = s_awid[wr_gnt];
  assign m_awaddr  = s_awaddr[wr_gnt];
  assign m_awsize  = s_awsize[wr_gnt];
  assign m_awlen   = s_awlen[wr_gnt];
  assign m_wdata   = s_wdata[wr_gnt];
  assign m_wstrb   = s_wstrb[wr_gnt];
  assign m_wlast   = s_wlast[wr_gnt];

  // Response payloads are broadcast; only the valid is steered.
  assign s_rid   = {N_IF{m_rid}};
  assign s_rdata = {N_IF{m_rdata}};
  assign s_rlast = {N_IF{m_rlast}};
  assign s_rresp = {N_IF{m_rresp}};
  assign s_bid   = {N_IF{m_bid}};
  assign s_bresp = {N_IF{m_bresp}};

endmodule

// File: doc/scr1_tb_axi_arbiter.md
# scr1_tb_axi_arbiter

Testbench-side N_IF-to-1 AXI4 arbiter that shares a single-port AXI memory model between several core masters (e.g. IMEM and DMEM bridges). Independent read and write arbiters grant one requester at a time with round-robin priority. Each arbiter forwards exactly one single-beat transaction and holds the grant until the response handshake completes. It sits between the core's AXI bridges and the memory model instance configured with N_IF = 1.

## Interface
Parameters:
- N_IF, 2, number of upstream requesters (2..8)
- W_ID, 4, AXI ID width
- W_ADR, 32, address width
- W_DATA, 32, data width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- s_aw{valid,id,addr,size,len}  in  N_IF×{1,W_ID,W_ADR,3,8}  upstream write address; s_awready out N_IF
- s_w{valid,data,strb,last}  in  N_IF×{1,W_DATA,W_DATA/8,1}  upstream write data; s_wready out N_IF
- s_b{valid,id,resp}  out  N_IF×{1,W_ID,2}  upstream write response; s_bready in N_IF
- s_ar{valid,id,addr,burst,size,len}  in  N_IF×{1,W_ID,W_ADR,2,3,8}  upstream read address; s_arready out N_IF
- s_r{valid,id,data,last,resp}  out  N_IF×{1,W_ID,W_DATA,1,2}  upstream read data; s_rready in N_IF
- m_aw*, m_w*, m_ar*  out  single-port versions of the above to memory; m_awready, m_wready, m_arready in 1
- m_b*, m_r*  in  single-port responses from memory; m_bready, m_rready out 1

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any s_arvalid, choose the winner by round-robin starting at rd_ptr. Register rd_gnt = winner and rd_ptr = (winner+1) mod N_IF, then go to R_ADDR.
  - R_ADDR: m_arvalid = s_arvalid[rd_gnt]; m_ar payload = s_ar*[rd_gnt]; s_arready[rd_gnt] = m_arready. On m_arvalid&m_arready, go to R_DATA.
  - R_DATA: s_rvalid[rd_gnt] = m_rvalid; m_rready = s_rready[rd_gnt]. On m_rvalid&m_rready&m_rlast, go to R_IDLE.
- Write FSM states: W_IDLE, W_XFER, W_RESP.
  - Request from i = s_awvalid[i] | s_wvalid[i]. Arbitration uses wr_ptr / wr_gnt, same rule as the read FSM.
  - W_XFER: forward AW and W channels from wr_gnt. Sticky flags aw_done and w_done are set on their respective downstream handshakes; an already-completed channel has its valid masked to 0. Go to W_RESP when both are done, counting the current cycle's handshakes.
  - W_RESP: s_bvalid[wr_gnt] = m_bvalid; m_bready = s_bready[wr_gnt]. On handshake, go to W_IDLE and clear the flags.
- Non-granted requesters: every s_*ready and s_*valid output is 0.
- Response payloads (id, data, resp, last) are broadcast to all requesters. IDs pass through unmodified.
- Read and write FSMs are fully independent. The same requester may hold both grants at once.
- Only len = 0 is supported. m_*len is forwarded as-is.
- A requester that deasserts valid while granted (an AXI violation) does not cause release. The FSM waits in its current state.

## Timing
- Reset (rst = 1 at a posedge): both FSMs go to IDLE, pointers = 0, flags = 0. Every valid/ready output is 0 from the next cycle. Payload outputs are don't-care while their valid is 0.
- Reset mid-transaction aborts without issuing a response. After reset, requester 0 has top priority.
- Arbitration latency is 1 cycle: s_arvalid seen at cycle 0 gives m_arvalid at cycle 1.
- Handshakes pass through combinationally (no buffering); ready/valid paths are purely combinational from state and grant.
- Minimum back-to-back read per arbiter is 3 cycles plus memory latency: IDLE → ADDR → DATA → IDLE.
- Round-robin fairness: with all N_IF requesting continuously, grants rotate 0,1,…,N_IF-1.
- A requester whose valid rises in the same cycle as the winner is chosen waits for the next IDLE.

## Test plan
- Single read: s_arvalid[1] = 1, addr 0x100, memory word 0xDEADBEEF → m_araddr = 0x100 at cycle 1; s_rvalid[1] with rdata 0xDEADBEEF; s_rvalid[0] stays 0.
- Contention: both requesters assert arvalid continuously, 4 reads each → grant order 0,1,0,1,0,1,0,1; no starvation.
- Write with W before AW: s_wvalid[0] at cycle 0, s_awvalid[0] at cycle 3, addr 0x40, data 0x12345678, strb 0xF → exactly one m_aw and one m_w handshake; a single s_bvalid[0]; a readback returns 0x12345678.
- Concurrent read by 0 and write by 1 → both proceed in parallel; responses are routed only to their owners.
- Backpressure: s_rready[0] = 0 for 5 cycles after rvalid → m_rready = 0 throughout; FSM stays in R_DATA; a competing read from 1 is not granted until the handshake.
- Reset asserted in W_XFER after the AW handshake → next cycle all valids/readies are 0; a fresh write from requester 1 completes normally.
